// File: rtl/mfp_eic_signal_filter.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_eic_signal_filter
//  Purpose  : Input conditioning for the AHB-Lite EIC. Raw asynchronous
//             interrupt lines are synchronised into HCLK, passed through a
//             per-channel glitch filter and presented on `signal`. A
//             registered one-cycle `change` strobe marks every toggle of
//             `signal` for debug/trace.
//  Ports    : HCLK        - system clock
//             HRESETn     - synchronous active-low reset
//             raw_signal  - asynchronous interrupt lines [CHANNELS]
//             filter_en   - per-channel filter enable (0 = bypass filter)
//             filter_len  - global acceptance threshold [CNT_WIDTH]
//             signal      - conditioned lines to the EIC (registered)
//             change      - one-cycle toggle strobe per channel (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module mfp_eic_signal_filter #(
    parameter int CHANNELS    = 40,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [CHANNELS-1:0]  raw_signal,
    input  logic [CHANNELS-1:0]  filter_en,
    input  logic [CNT_WIDTH-1:0] filter_len,
    output logic [CHANNELS-1:0]  signal,
    output logic [CHANNELS-1:0]  change
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Synchroniser chain: stage 0 captures the pins, last stage feeds the filter.
    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  sync_last;

    logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];

    logic [CHANNELS-1:0]  signal_q;
    logic [CHANNELS-1:0]  signal_d;
    // Copy of signal from the previous edge; change is derived from it so the
    // strobe follows the toggle by one full cycle.
    logic [CHANNELS-1:0]  signal_dly_q;
    logic [CHANNELS-1:0]  change_q;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Synchroniser: plain flop chain, nothing between the stages.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_q[st] <= '0;
            end
        end else begin
            sync_q[0] <= raw_signal;
            for (int st = 1; st < SYNC_STAGES; st++) begin
                sync_q[st] <= sync_q[st-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Filter next-state. The counter measures how many consecutive edges
    // the synchronised input has disagreed with the output; the new level
    // is taken once that run has reached filter_len. Because the counter
    // only increments while strictly below filter_len it never wraps, and
    // the >= test lets a lowered filter_len take effect immediately.
    // ------------------------------------------------------------------
    always_comb begin
        signal_d = signal_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = '0;
            if (!filter_en[ch]) begin
                signal_d[ch] = sync_last[ch];
            end else if (sync_last[ch] == signal_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] >= filter_len) begin
                signal_d[ch] = sync_last[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Filter state, output and change strobe registers.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
            signal_q     <= '0;
            signal_dly_q <= '0;
            change_q     <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            signal_q     <= signal_d;
            signal_dly_q <= signal_q;
            change_q     <= signal_q ^ signal_dly_q;
        end
    end

    assign signal = signal_q;
    assign change = change_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_eic_signal_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfp_eic_signal_filter
//  Purpose  : Directed self-checking bench for mfp_eic_signal_filter with
//             default parameters (40 channels, 2 sync stages, 4-bit counter).
//             Expected vectors are hand-derived from the edge-level timing:
//             a raw level driven before edge k is in stage 0 after k, in the
//             last sync stage after k+1, and on signal after k+2+filter_len.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_eic_signal_filter;

    localparam int CH = 40;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [CH-1:0] raw_signal;
    logic [CH-1:0] filter_en;
    logic [3:0]    filter_len;
    logic [CH-1:0] signal;
    logic [CH-1:0] change;

    logic [CH-1:0] e_sig;
    logic [CH-1:0] e_chg;
    logic [9:0]    pat;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    mfp_eic_signal_filter #(
        .CHANNELS    (CH),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .raw_signal (raw_signal),
        .filter_en  (filter_en),
        .filter_len (filter_len),
        .signal     (signal),
        .change     (change)
    );

    // Advance through one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESETn    = 1'b0;
        raw_signal = '1;
        filter_en  = '0;
        filter_len = 4'd0;

        // Reset held for two edges with all inputs high.
        for (int n = 1; n <= 2; n++) begin
            step();
            chk("rst_sig", signal, '0);
            chk("rst_chg", change, '0);
        end

        // Release: bypass channels rise on the third edge, strobe one later.
        HRESETn = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            e_sig = (n >= 3) ? {CH{1'b1}} : {CH{1'b0}};
            e_chg = (n == 4) ? {CH{1'b1}} : {CH{1'b0}};
            chk("byp_rel_sig", signal, e_sig);
            chk("byp_rel_chg", change, e_chg);
        end

        // Clean restart with all filters enabled, filter_len = 3.
        HRESETn    = 1'b0;
        raw_signal = '0;
        filter_en  = '1;
        filter_len = 4'd3;
        step();
        step();
        HRESETn = 1'b1;

        // Latency: step on channel 0, appears on edge k+5, strobe on k+6.
        raw_signal[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            e_sig = '0; e_sig[0] = (n >= 6);
            e_chg = '0; e_chg[0] = (n == 7);
            chk("lat_sig", signal, e_sig);
            chk("lat_chg", change, e_chg);
        end

        // 3-cycle glitch on channel 1 is swallowed.
        for (int n = 1; n <= 12; n++) begin
            raw_signal[1] = (n <= 3);
            step();
            e_sig = '0; e_sig[0] = 1'b1;
            chk("gl3_sig", signal, e_sig);
            chk("gl3_chg", change, '0);
        end

        // 4-cycle pulse on channel 1 passes: rises at k+5, falls at k+9.
        for (int n = 1; n <= 12; n++) begin
            raw_signal[1] = (n <= 4);
            step();
            e_sig = '0; e_sig[0] = 1'b1; e_sig[1] = (n >= 6 && n <= 9);
            e_chg = '0; e_chg[1] = (n == 7 || n == 11);
            chk("gl4_sig", signal, e_sig);
            chk("gl4_chg", change, e_chg);
        end

        // Broken run on channel 32, filter_len = 5: 1,1,1,0 then held high.
        filter_len = 4'd5;
        pat = 10'b11_1111_0111;
        for (int n = 1; n <= 14; n++) begin
            raw_signal[32] = (n <= 10) ? pat[n-1] : 1'b1;
            step();
            e_sig = '0; e_sig[0] = 1'b1; e_sig[32] = (n >= 12);
            e_chg = '0; e_chg[32] = (n == 13);
            chk("brk_sig", signal, e_sig);
            chk("brk_chg", change, e_chg);
        end

        // Bypass (ch2) and transparent filter (ch3, filter_len = 0), 1-cycle pulse.
        filter_en[2] = 1'b0;
        filter_len   = 4'd0;
        for (int n = 1; n <= 6; n++) begin
            raw_signal[2] = (n == 1);
            raw_signal[3] = (n == 1);
            step();
            e_sig = '0; e_sig[0] = 1'b1; e_sig[32] = 1'b1;
            e_sig[2] = (n == 3); e_sig[3] = (n == 3);
            e_chg = '0;
            e_chg[2] = (n == 4 || n == 5); e_chg[3] = (n == 4 || n == 5);
            chk("bt_sig", signal, e_sig);
            chk("bt_chg", change, e_chg);
        end

        // Reset mid-count: filter_len = 8, channel 5 high for 6 edges, then reset.
        filter_len    = 4'd8;
        raw_signal[5] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            e_sig = '0; e_sig[0] = 1'b1; e_sig[32] = 1'b1;
            chk("rmc_pre_sig", signal, e_sig);
            chk("rmc_pre_chg", change, '0);
        end
        HRESETn = 1'b0;
        step();
        chk("rmc_rst_sig", signal, '0);
        chk("rmc_rst_chg", change, '0);
        HRESETn = 1'b1;
        // Held-high channels need 2 sync edges plus a full 9-edge run again.
        for (int m = 1; m <= 12; m++) begin
            step();
            e_sig = '0;
            if (m >= 11) begin
                e_sig[0] = 1'b1; e_sig[5] = 1'b1; e_sig[32] = 1'b1;
            end
            e_chg = '0;
            if (m == 12) begin
                e_chg[0] = 1'b1; e_chg[5] = 1'b1; e_chg[32] = 1'b1;
            end
            chk("rmc_post_sig", signal, e_sig);
            chk("rmc_post_chg", change, e_chg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfp_eic_signal_filter.md
Name: mfp_eic_signal_filter

Overview:
Input-conditioning stage directly upstream of the AHB-Lite EIC. It takes raw, asynchronous interrupt lines from pins and peripherals and synchronises them into the HCLK domain. A per-channel glitch filter then removes short pulses, and the result drives the EIC `signal` input. It also emits a one-cycle change strobe per channel for debug and trace.

Parameters:
CHANNELS, 40, number of interrupt lines; equals EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS.
SYNC_STAGES, 2, synchroniser flop depth per channel; legal range 2..4.
CNT_WIDTH, 4, width of each per-channel filter counter and of filter_len.

Ports:
HCLK  input  1  system clock.
HRESETn  input  1  synchronous, active-low reset.
raw_signal  input  CHANNELS  asynchronous interrupt lines.
filter_en  input  CHANNELS  per-channel filter enable; 0 = bypass filter, keep synchroniser.
filter_len  input  CNT_WIDTH  global filter threshold; quasi-static, driven from a config register.
signal  output  CHANNELS  conditioned lines to the EIC `signal` port; registered.
change  output  CHANNELS  one-cycle pulse when the corresponding signal bit toggles; registered.

Behaviour:
- Clock and reset
  - All state updates on posedge HCLK.
  - HRESETn=0 sampled at an edge clears all synchroniser flops, all counters, signal and change to 0.
  - Reset asserted mid-filtering discards counts in progress. No partial state survives.
- Synchroniser
  - Per channel, a SYNC_STAGES-deep flop chain. Its last stage is s[i].
  - No logic between sync stages.
- Per-channel filter, evaluated each edge, in priority order:
  1. filter_en[i]=0: signal[i] <= s[i]; cnt[i] <= 0.
  2. s[i]==signal[i]: cnt[i] <= 0 (disagreement run broken).
  3. cnt[i] >= filter_len: signal[i] <= s[i]; cnt[i] <= 0.
  4. Otherwise: cnt[i] <= cnt[i]+1.
- Acceptance and latency
  - A new level is accepted only after filter_len+1 consecutive cycles of s[i] differing from signal[i].
  - A raw step first sampled at edge k appears on signal at edge k+SYNC_STAGES+filter_len.
  - Sync output pulses of at most filter_len cycles are rejected completely, with no output activity.
  - filter_len=0: the filter is transparent. Latency equals the bypass path: SYNC_STAGES+1 registers.
- Counter
  - Never exceeds filter_len, so no wrap.
  - The `>=` comparison means a filter_len reduced mid-count takes effect on the next edge.
  - Max filter_len = 2^CNT_WIDTH-1 = 15 gives a 16-cycle acceptance window.
- change[i]
  - 1 for exactly the cycle following an edge where signal[i] changed value; 0 otherwise.
  - Works in both filtered and bypass modes.
- filter_en toggling
  - Switching 1→0 drops the count and signal follows s[i] next edge.
  - Switching 0→1 starts counting from 0.
- Channels are fully independent. Simultaneous transitions on any subset are handled in parallel.
- Width rules: cnt and filter_len are unsigned CNT_WIDTH. The comparison is unsigned.

Test Plan:
- Reset/idle: hold HRESETn=0 for 2 edges with raw_signal=all-1 → signal=0 and change=0 throughout reset. After release, bypass channels (filter_en=0) rise 3 edges later.
- Latency: filter_len=3, filter_en=all-1, raw_signal[0] 0→1 at edge k and held → signal[0]=1 first at edge k+5; change[0]=1 for one cycle at k+6; other channels stay 0.
- Glitch reject/accept: filter_len=3, raw_signal[1] high for 3 cycles → signal[1] never toggles, change[1] stays 0. Repeat with 4 cycles → signal[1] rises once and falls again after the return to 0 plus the same latency.
- Broken run: filter_len=5, raw_signal[32] pattern 1,1,1,0,1,1,1,1,1,1 → counter restarts after the 0. signal[32] rises 6 cycles after the second run begins at s.
- Bypass and transparent: filter_en[2]=0 and filter_len=0 on channel 3, 1-cycle pulse on both → both pulses pass with SYNC_STAGES+1 latency. change pulses occur on rise and on fall.
- Reset mid-count: filter_len=8, raw_signal[5]=1 for 6 cycles, then HRESETn=0 for 1 edge, input held high → signal[5] rises only after a full 9-cycle run following the reset plus sync delay.
